// File: rtl/pong_pkg.sv
// Shared types and constants for the pong button-conditioning path.
package pong_pkg;

   // Debounce FSM states: two stable levels, each with a qualification wait.
   typedef enum logic [1:0] {
      DB_IDLE,
      DB_PRESS_WAIT,
      DB_HELD,
      DB_RELEASE_WAIT
   } db_state_t;

   // Default number of consecutive stable samples needed to accept a change.
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;

endpackage

// File: rtl/debounce_fsm.sv
// One-button conditioner: 2-FF synchroniser, debounce FSM with a stability
// counter, and a one-cycle press pulse on each accepted rising level.
module debounce_fsm
   import pong_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic pixel_clk,
   input  logic rst,
   input  logic raw,
   output logic db,
   output logic press
);

   // Counter only ever reaches DEBOUNCE_CYCLES-1, so this width never wraps.
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s1;
   logic             s2;
   db_state_t        state;
   db_state_t        state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             db_q;

   // Bring the asynchronous button into the pixel_clk domain.
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // FSM state and stability counter registers.
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         state <= DB_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic: a level change is accepted only after it has been
   // seen on DEBOUNCE_CYCLES consecutive samples; any reversal restarts.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         DB_IDLE: begin
            if (s2) begin
               state_next = DB_PRESS_WAIT;
               cnt_next   = CNT_ONE;
            end
         end
         DB_PRESS_WAIT: begin
            if (!s2) begin
               state_next = DB_IDLE;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = DB_HELD;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end
         DB_HELD: begin
            if (!s2) begin
               state_next = DB_RELEASE_WAIT;
               cnt_next   = CNT_ONE;
            end
         end
         DB_RELEASE_WAIT: begin
            if (s2) begin
               state_next = DB_HELD;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = DB_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CNT_ONE;
            end
         end
         default: begin
            state_next = DB_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // The debounced level is a pure decode of the registered state.
   assign db = (state == DB_HELD) || (state == DB_RELEASE_WAIT);

   // Register a single-cycle pulse on each 0->1 transition of db.
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         db_q  <= 1'b0;
         press <= 1'b0;
      end else begin
         db_q  <= db;
         press <= db & ~db_q;
      end
   end

endmodule

// File: rtl/button_cond.sv
// Paddle button conditioner: debounces both buttons and arbitrates them into
// mutually exclusive right/left levels.
// Optional macro BUTTON_LAST_WINS_EN: when both buttons are held, the most
// recently accepted one wins (right on a tie); otherwise both outputs drop.
module button_cond
   import pong_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic pixel_clk,
   input  logic rst,
   input  logic btn_right_raw,
   input  logic btn_left_raw,
   output logic right,
   output logic left,
   output logic right_press,
   output logic left_press
);

   logic db_r;
   logic db_l;
   logic right_win;
   logic left_win;

   debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_right (
      .pixel_clk(pixel_clk),
      .rst      (rst),
      .raw      (btn_right_raw),
      .db       (db_r),
      .press    (right_press)
   );

   debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_left (
      .pixel_clk(pixel_clk),
      .rst      (rst),
      .raw      (btn_left_raw),
      .db       (db_l),
      .press    (left_press)
   );

`ifdef BUTTON_LAST_WINS_EN
   logic db_r_q;
   logic db_l_q;
   logic last_left;
   logic pick_left;

   // Track db history and remember which button rose most recently.
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         db_r_q    <= 1'b0;
         db_l_q    <= 1'b0;
         last_left <= 1'b0;
      end else begin
         db_r_q    <= db_r;
         db_l_q    <= db_l;
         last_left <= pick_left;
      end
   end

   // A fresh rise takes priority over history; right wins a same-cycle tie.
   always_comb begin
      pick_left = last_left;
      if (db_r && !db_r_q) begin
         pick_left = 1'b0;
      end else if (db_l && !db_l_q) begin
         pick_left = 1'b1;
      end
   end

   // Conflict resolved in favour of the last winner.
   always_comb begin
      right_win = db_r && (!db_l || !pick_left);
      left_win  = db_l && (!db_r ||  pick_left);
   end
`else
   // Conflict holds the paddle still.
   always_comb begin
      right_win = db_r && !db_l;
      left_win  = db_l && !db_r;
   end
`endif

   // Registered, mutually exclusive output levels.
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         right <= 1'b0;
         left  <= 1'b0;
      end else begin
         right <= right_win;
         left  <= left_win;
      end
   end

endmodule
